csr_uart_char: RTL and testbench

CSR-mapped character UART (8N1) for the RudolV pipeline's CSR bus. It occupies one CSR address, 0xBC0 by default.
- A CSR write with the low byte as data starts transmission of one character.
- A CSR read returns transmitter status plus the oldest pending received byte, and consumes that byte.
- rdata/valid are registered and zero when the block is not addressed, so a top level can OR them with other CSR slaves.

---
 rtl/csr_uart_char_if.sv | 27 ++
 rtl/csr_uart_char.sv | 190 +++++++++++++++++++
 tb/tb_csr_uart_char.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_uart_char_if.sv
// CSR bus bundle for csr_uart_char.
//
// Bus semantics: there is no ready. The master presents addr, read,
// modify and wdata for one clock. The slave answers one clock later with
// registered valid (address matched) and rdata. Both are zero when the
// slave is not addressed, so several slaves can be OR-ed together.
// rx_state_dbg / tx_state_dbg expose the internal FSM states for checkers.
interface csr_uart_char_if;
    logic        read;
    logic [2:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic [1:0]  rx_state_dbg;
    logic        tx_state_dbg;

    modport master (
        output read, modify, wdata, addr,
        input  rdata, valid, rx_state_dbg, tx_state_dbg
    );

    modport slave (
        input  read, modify, wdata, addr,
        output rdata, valid, rx_state_dbg, tx_state_dbg
    );
endinterface

// File: rtl/csr_uart_char.sv
// CSR-mapped 8N1 character UART occupying a single CSR address.
// A write (modify 001) sends wdata[7:0]; a read returns
// {tx_busy, 22'b0, rx_valid, rx_byte} and consumes the pending byte.
// Optional build macro CSR_UART_LOOPBACK_EN feeds the receiver from the
// internal tx signal instead of the rx pin.
module csr_uart_char #(
    parameter int unsigned CLOCK_RATE = 12_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter logic [11:0] BASE_ADDR  = 12'hBC0
) (
    input  logic           clk,
    input  logic           rstn,
    csr_uart_char_if.slave bus,
    input  logic           rx,
    output logic           tx
);
    // Clocks per bit; must be at least 2.
    localparam int unsigned DIV = CLOCK_RATE / BAUD_RATE;
    localparam int unsigned CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bits;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_src;
    logic          rx_meta;
    logic          rx_sync;

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bits;
    logic [8:0]    tx_shift;
    logic          tx_busy;

    logic select;
    logic tx_load;
    logic consume;
    logic unused_wdata;

    assign select  = (bus.addr == BASE_ADDR);
    assign tx_load = select && (bus.modify == 3'b001) && !tx_busy;
    assign consume = select && bus.read && rx_valid;

    assign unused_wdata     = ^bus.wdata[31:8];
    assign bus.rx_state_dbg = rx_state;
    assign bus.tx_state_dbg = tx_state;

`ifdef CSR_UART_LOOPBACK_EN
    logic unused_rx_pin;
    assign unused_rx_pin = rx;
    assign rx_src        = tx;
`else
    assign rx_src = rx;
`endif

    // Two-flop synchronizer for the asynchronous serial input.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_src;
            rx_sync <= rx_meta;
        end
    end

    // Receiver: find start edge, confirm at mid-bit, sample 8 data bits and
    // the stop bit at bit centres. A completing byte overrides a consume.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            if (consume) begin
                rx_valid <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= CNT_HALF;
                    end
                end
                RX_START: begin
                    if (rx_cnt == '0) begin
                        if (!rx_sync) begin
                            rx_state <= RX_DATA;
                            rx_cnt   <= CNT_BIT;
                            rx_bits  <= '0;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_cnt   <= CNT_BIT;
                        rx_bits  <= rx_bits + 1'b1;
                        if (rx_bits == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == '0) begin
                        if (rx_sync) begin
                            rx_byte  <= rx_shift;
                            rx_valid <= 1'b1;
                        end
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Transmitter: start bit goes out the cycle after the load, then d0..d7
    // and the stop bit; busy drops once the stop bit has lasted DIV clocks.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_shift <= '1;
            tx_busy  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_load) begin
                        tx_state <= TX_SEND;
                        tx_shift <= {1'b1, bus.wdata[7:0]};
                        tx_cnt   <= CNT_BIT;
                        tx_bits  <= '0;
                        tx_busy  <= 1'b1;
                        tx       <= 1'b0;
                    end
                end
                TX_SEND: begin
                    if (tx_cnt == '0) begin
                        if (tx_bits == 4'd9) begin
                            tx_state <= TX_IDLE;
                            tx_busy  <= 1'b0;
                            tx       <= 1'b1;
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[8:1]};
                            tx_bits  <= tx_bits + 1'b1;
                            tx_cnt   <= CNT_BIT;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // CSR response: registered and zero unless addressed, using the
    // status as it stood before this cycle's updates.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus.valid <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.valid <= select;
            bus.rdata <= select ? {tx_busy, 22'b0, rx_valid, rx_byte} : 32'h0;
        end
    end
endmodule

// File: tb/tb_csr_uart_char.sv
// Self-checking bench for csr_uart_char with DIV = 16.
// Define CSR_UART_LOOPBACK_EN for both RTL and bench to test loopback.
`timescale 1ns/1ps
module tb_csr_uart_char;
    localparam int unsigned CLOCK_RATE = 16_000_000;
    localparam int unsigned BAUD_RATE  = 1_000_000;
    localparam int         DIV         = 16;
    localparam logic [11:0] BASE       = 12'hBC0;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic rx   = 1'b1;
    logic tx;

    csr_uart_char_if bus();

    csr_uart_char #(
        .CLOCK_RATE(CLOCK_RATE),
        .BAUD_RATE (BAUD_RATE),
        .BASE_ADDR (BASE)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus),
        .rx  (rx),
        .tx  (tx)
    );

    // Clock and counters
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    // Reference model of the receive side: pending byte and its flag.
    logic       m_valid = 1'b0;
    logic [7:0] m_byte  = 8'h00;

    logic [31:0] r1;
    logic [31:0] r2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Driver tasks: all start and end just after a falling edge.
    task automatic bus_idle();
        bus.read   = 1'b0;
        bus.modify = 3'b000;
        bus.wdata  = 32'h0;
        bus.addr   = 12'h000;
    endtask

    task automatic csr_read(output logic [31:0] d);
        bus.addr = BASE;
        bus.read = 1'b1;
        @(negedge clk);
        d = bus.rdata;
        bus.read = 1'b0;
        bus.addr = 12'h000;
    endtask

    task automatic csr_write(input logic [7:0] b, input logic [2:0] code);
        bus.addr   = BASE;
        bus.modify = code;
        bus.wdata  = {24'($urandom), b};
        @(negedge clk);
        bus_idle();
    endtask

    // Read through the scoreboard: expected status from the model.
    task automatic read_and_score(input string tag);
        logic [31:0] d;
        exp_q.push_back({1'b0, 22'b0, m_valid, m_byte});
        csr_read(d);
        check(tag, d, exp_q.pop_front());
        m_valid = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (DIV) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_frame(b, stop_bit);
        if (stop_bit) begin
            m_valid = 1'b1;
            m_byte  = b;
        end
        repeat (2 * DIV) @(negedge clk);
    endtask

    // Write one byte and check the whole serial waveform plus busy status.
    task automatic tx_frame(input logic [7:0] b, input logic try_drop);
        logic [9:0] f;
        logic       exp_bit;
        f = {1'b1, b, 1'b0};
        bus.addr   = BASE;
        bus.modify = 3'b001;
        bus.wdata  = {24'($urandom), b};
        @(posedge clk);
        for (int k = 0; k < 10 * DIV + 16; k++) begin
            @(negedge clk);
            if (k == 0) bus.modify = 3'b000;
            exp_bit = (k < 10 * DIV) ? f[k / DIV] : 1'b1;
            check("tx_bit", tx, exp_bit);
            check("tx_busy", bus.rdata[31], (k >= 1 && k <= 10 * DIV));
            if (try_drop && k == 60) begin
                bus.modify = 3'b001;
                bus.wdata  = 32'h0000_00AA;
            end
            if (k == 61) bus.modify = 3'b000;
        end
        bus_idle();
    endtask

    initial begin
        int n_old;
        int n_new;
        logic seen_new;
        logic is_old;
        logic [7:0] rb;
        logic rs;

        bus_idle();
        bus.addr = BASE;

        // Reset held for three clocks with the block addressed
        repeat (3) @(negedge clk);
        check("rst_valid_low", bus.valid, 1'b0);
        check("rst_tx", tx, 1'b1);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_valid", bus.valid, 1'b1);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_tx_idle", tx, 1'b1);
        bus.addr = 12'hBC1;
        @(negedge clk);
        check("nosel_valid", bus.valid, 1'b0);
        check("nosel_rdata", bus.rdata, 32'h0);
        bus_idle();
        repeat (2) @(negedge clk);

        // Transmit, with a dropped second write mid-frame
        tx_frame(8'h55, 1'b1);
        tx_frame(8'($urandom_range(0, 255)), 1'b0);

        // Set/clear codes must not start a frame
        csr_write(8'h42, 3'b010);
        csr_write(8'h42, 3'b011);
        bus.addr = BASE;
        repeat (20) begin
            @(negedge clk);
            check("ignored_tx", tx, 1'b1);
            check("ignored_busy", bus.rdata[31], 1'b0);
        end
        bus_idle();

        // Reset in the middle of a frame aborts it
        csr_write(8'hF0, 3'b001);
        repeat (30) @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_tx", tx, 1'b1);
        rstn = 1'b1;
        bus.addr = BASE;
        @(negedge clk);
        check("abort_rdata", bus.rdata, 32'h0);
        bus_idle();
        m_valid = 1'b0;
        m_byte  = 8'h00;
        repeat (4) @(negedge clk);

`ifdef CSR_UART_LOOPBACK_EN
        // Loopback: rx pin held low, byte comes back from tx
        rx = 1'b0;
        repeat (4) @(negedge clk);
        csr_write(8'h3C, 3'b001);
        repeat (10 * DIV + 4) @(negedge clk);
        csr_read(r1);
        check("loopback", r1, 32'h0000_013C);
        csr_read(r1);
        check("loopback_consumed", r1, 32'h0000_003C);
`else
        // Basic receive and consume
        send_frame(8'hA3, 1'b1);
        read_and_score("rx_a3");
        read_and_score("rx_a3_consumed");

        // Short low glitch is not a byte
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        read_and_score("rx_glitch");

        // Framing error leaves the flag clear
        send_frame(8'h5A, 1'b0);
        read_and_score("rx_framing");

        // Overrun keeps the newest byte
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        read_and_score("rx_overrun");
        read_and_score("rx_overrun_consumed");

        // Random frames, some with bad stop bits, random reads
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rb, rs);
            if ($urandom_range(0, 1) == 1) read_and_score("rx_random");
        end
        read_and_score("rx_random_final");

        // Read swept across the completion of byte 0x7E while 0x11 pending.
        // Every read before or at completion returns the old byte and the
        // next read the new one; later reads already see the new byte.
        n_old = 0;
        n_new = 0;
        seen_new = 1'b0;
        for (int j = 144; j <= 170; j++) begin
            drive_frame(8'h11, 1'b1);
            repeat (4) @(negedge clk);
            fork
                drive_frame(8'h7E, 1'b1);
                begin
                    repeat (j) @(negedge clk);
                    csr_read(r1);
                end
            join
            repeat (4) @(negedge clk);
            csr_read(r2);
            is_old = (r1 == 32'h0000_0111);
            check("simul_r1", (r1 == 32'h0000_0111 || r1 == 32'h0000_017E), 1);
            check("simul_r2", r2, is_old ? 32'h0000_017E : 32'h0000_007E);
            if (is_old) begin
                check("simul_order", seen_new, 1'b0);
                n_old++;
            end else begin
                seen_new = 1'b1;
                n_new++;
            end
            repeat (4) @(negedge clk);
        end
        check("simul_window", (n_old > 0 && n_new > 0), 1);
        m_valid = 1'b0;
        m_byte  = 8'h7E;
        read_and_score("rx_after_sweep");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
